fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Front end of the MIPS pipeline. Owns the PC, issues word fetches to instruction memory, and buffers returned instructions in a small FIFO.
- Feeds the decode stage with an instruction, its PC+4, and a valid/ready handshake.
- Accepts the redirect (taken branch, jump, jr target) produced by decode. On a redirect it flushes everything younger and drops any stale in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 4, fetch-queue entries (power of two, at least 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word address of the request (bits [1:0] always 0).
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid, at least 1 cycle after acceptance.
- imem_rdata  in  32  returned instruction word.
- redirect_valid  in  1  decode requests a PC change this cycle.
- redirect_pc  in  32  new fetch PC.
- instr_out  out  32  instruction at the queue head.
- pcplus4_out  out  32  PC+4 of the head instruction.
- out_valid  out  1  queue non-empty.
- dec_ready  in  1  decode consumes the head this cycle.

Behaviour:
- Reset (asynchronous, while resetn = 0):
  - pc = RESET_PC, state = IDLE.
  - Queue count = 0, read and write pointers = 0, pending_pc = 0.
  - imem_req = 0, out_valid = 0, instr_out = 0, pcplus4_out = 0.
- At most one request is outstanding at any time. State machine:
  - IDLE:
    - imem_req = !redirect_valid && count < DEPTH; imem_addr = pc.
    - On imem_req && imem_ready: pending_pc <= pc, pc <= pc + 4 (32-bit wrap), go to WAIT.
  - WAIT:
    - imem_req = 0.
    - On imem_rvalid with no redirect: push {imem_rdata, pending_pc + 4}, go to IDLE.
    - On redirect_valid without imem_rvalid: go to DROP.
    - On redirect_valid and imem_rvalid in the same cycle: discard the response, go to IDLE.
  - DROP:
    - imem_req = 0.
    - On imem_rvalid: discard the data, go to IDLE.
    - A further redirect while in DROP only updates pc.
- Redirect (any state):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - Queue flushed: count <= 0, pointers <= 0.
  - A pop or push in the same cycle is cancelled.
  - No request is issued in the redirect cycle. The first request at the new PC appears the next cycle at the earliest.
- Queue:
  - out_valid = (count != 0); instr_out and pcplus4_out come from the head entry, combinationally.
  - Pop occurs on out_valid && dec_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Issue is gated on count < DEPTH while in IDLE, so a response always has a free slot. Overflow is impossible, and a push while full is a design error (assertion).
  - Popping while empty has no effect.
- Throughput: one instruction per 2 cycles with 1-cycle memory latency (request, then response). Back-pressure from decode only stops issue once the queue is full.
- Latency: a request accepted in cycle N whose response arrives in cycle N+1 gives out_valid = 1 in cycle N+2.

Test Plan:
- Reset, then release with imem_ready = 1 and 1-cycle response latency, dec_ready = 1 → addresses 0x0, 0x4, 0x8 issued; pcplus4_out 0x4, 0x8, 0xC in order; out_valid first high 2 cycles after the first acceptance.
- dec_ready = 0 with DEPTH = 4 → exactly 4 pushes; imem_req stays 0 while count = 4; raising dec_ready for 1 cycle pops 1 entry and re-enables 1 request.
- Pulse redirect_valid with redirect_pc = 0x0000_1002 while in WAIT; response arrives 2 cycles later → response discarded, queue empty, next imem_addr = 0x0000_1000, pcplus4_out = 0x0000_1004.
- redirect_valid and imem_rvalid in the same cycle → no push, state IDLE, next request issues at the redirect target.
- Queue holding 3 entries plus a pop coinciding with a redirect → out_valid = 0 on the next cycle, no entry delivered twice.
- Deassert resetn mid-WAIT; return the late response after reset is released → pc = RESET_PC, state IDLE, count = 0; a late imem_rvalid arriving in IDLE is ignored (no push, since pushes occur only in WAIT).

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS front end. Owns the fetch PC, keeps at most one
// instruction-memory request in flight, and buffers returned words in a
// small FIFO that feeds decode through a valid/ready handshake. A redirect
// from decode flushes the FIFO and drops any in-flight response.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pcplus4_out,
  output logic        out_valid,
  input  logic        dec_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [31:0]     r_pc;
  logic [31:0]     r_pending_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [31:0]     r_instr_q [DEPTH];
  logic [31:0]     r_pc4_q   [DEPTH];

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_accept;
  logic [31:0]     w_redirect_aligned;

  assign w_full             = (r_count == CW'(DEPTH));
  assign w_empty            = (r_count == '0);
  assign w_accept           = imem_req && imem_ready;
  assign w_pop              = !w_empty && dec_ready && !redirect_valid;
  assign w_redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  assign imem_addr   = r_pc;
  assign out_valid   = !w_empty;
  assign instr_out   = r_instr_q[r_rd_ptr];
  assign pcplus4_out = r_pc4_q[r_rd_ptr];

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state, request issue and push decision. imem_req is also gated by
  // resetn so the request stays low while reset is asserted.
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        imem_req = resetn && !redirect_valid && !w_full;
        if (imem_req && imem_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = S_IDLE;
          w_push      = !redirect_valid;
        end else if (redirect_valid) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch PC and the PC of the outstanding request; redirect has priority.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc         <= RESET_PC & 32'hFFFF_FFFC;
      r_pending_pc <= '0;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_aligned;
    end else if (w_accept) begin
      r_pc         <= r_pc + 32'd4;
      r_pending_pc <= r_pc;
    end
  end

  // Queue pointers and occupancy; a redirect flushes and cancels push/pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (redirect_valid) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_instr_q[i] <= '0;
        r_pc4_q[i]   <= '0;
      end
    end else if (w_push) begin
      r_instr_q[r_wr_ptr] <= imem_rdata;
      r_pc4_q[r_wr_ptr]   <= r_pending_pc + 32'd4;
    end
  end

  // Issue is gated on a free slot, so a push into a full queue is a bug.
  assert property (@(posedge clk) disable iff (!resetn) !(w_push && w_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fill/drain, back-pressure, redirects in
// WAIT and with coinciding response or pop, and reset during WAIT.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] pcplus4_out;
  logic        out_valid;
  logic        dec_ready;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_out     (instr_out),
    .pcplus4_out   (pcplus4_out),
    .out_valid     (out_valid),
    .dec_ready     (dec_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Cycle in IDLE expecting a request at exp_addr, memory ready.
  task automatic issue(input string tag, input logic [31:0] exp_addr);
    cyc();
    imem_ready     = 1'b1;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk({tag, "_req"}, imem_req, 1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
  endtask

  // Cycle in WAIT returning data.
  task automatic respond(input string tag, input logic [31:0] data);
    cyc();
    imem_rvalid    = 1'b1;
    imem_rdata     = data;
    redirect_valid = 1'b0;
    #1;
    chk({tag, "_req"}, imem_req, 0);
  endtask

  task automatic idle_cyc();
    cyc();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    resetn = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_pc4", pcplus4_out, 0);
    chk("rst_addr", imem_addr, 32'h0);
    cyc();
    resetn = 1'b1; dec_ready = 1'b1;

    // Streaming with dec_ready = 1
    issue("s1_i0", 32'h0);      chk("s1_v0", out_valid, 0);
    respond("s1_r0", 32'hA000_0000); chk("s1_v1", out_valid, 0);
    issue("s1_i1", 32'h4);      chk("s1_v2", out_valid, 1);
    chk("s1_pc4_0", pcplus4_out, 32'h4); chk("s1_ins0", instr_out, 32'hA000_0000);
    respond("s1_r1", 32'hA000_0001); chk("s1_v3", out_valid, 0);
    issue("s1_i2", 32'h8);
    chk("s1_pc4_1", pcplus4_out, 32'h8); chk("s1_ins1", instr_out, 32'hA000_0001);
    respond("s1_r2", 32'hA000_0002);
    issue("s1_i3", 32'hC);
    chk("s1_pc4_2", pcplus4_out, 32'hC); chk("s1_ins2", instr_out, 32'hA000_0002);

    // Back-pressure: fill to DEPTH
    respond("s2_r3", 32'hA000_0003); dec_ready = 1'b0;
    issue("s2_i4", 32'h10);     chk("s2_pc4_3", pcplus4_out, 32'h10);
    respond("s2_r4", 32'hA000_0004);
    issue("s2_i5", 32'h14);
    respond("s2_r5", 32'hA000_0005);
    issue("s2_i6", 32'h18);
    respond("s2_r6", 32'hA000_0006);
    idle_cyc();
    chk("s2_full_req0", imem_req, 0); chk("s2_full_v", out_valid, 1);
    chk("s2_head_pc4", pcplus4_out, 32'h10); chk("s2_head_ins", instr_out, 32'hA000_0003);
    idle_cyc();
    chk("s2_full_req1", imem_req, 0);
    dec_ready = 1'b1;
    issue("s2_i7", 32'h1C);
    dec_ready = 1'b0;
    chk("s2_pc4_4", pcplus4_out, 32'h14);
    respond("s2_r7", 32'hA000_0007);
    idle_cyc();
    chk("s2_full_req2", imem_req, 0);
    imem_ready = 1'b0; dec_ready = 1'b1;

    // Drain with memory not ready
    idle_cyc();
    chk("d_req", imem_req, 1); chk("d_addr", imem_addr, 32'h20);
    chk("d_pc4_5", pcplus4_out, 32'h18);
    idle_cyc(); chk("d_pc4_6", pcplus4_out, 32'h1C);
    idle_cyc(); chk("d_pc4_7", pcplus4_out, 32'h20); chk("d_ins7", instr_out, 32'hA000_0007);
    idle_cyc(); chk("d_empty", out_valid, 0);

    // Redirect while WAIT, late response dropped
    issue("s3_i", 32'h20);
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1002; imem_rvalid = 1'b0;
    #1;
    chk("s3_redir_req", imem_req, 0);
    idle_cyc();
    chk("s3_drop_req", imem_req, 0); chk("s3_drop_v", out_valid, 0);
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("s3_late_req", imem_req, 0);
    issue("s3_new", 32'h1000);  chk("s3_v", out_valid, 0);
    respond("s3_r", 32'hB000_0000);
    issue("s3_i2", 32'h1004);
    chk("s3_v2", out_valid, 1); chk("s3_pc4", pcplus4_out, 32'h1004);
    chk("s3_ins", instr_out, 32'hB000_0000);

    // Redirect and response in the same cycle
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    #1;
    chk("s4_req", imem_req, 0);
    issue("s4_new", 32'h2000);  chk("s4_v", out_valid, 0);
    dec_ready = 1'b0;

    // Three entries, pop coinciding with redirect
    respond("s5_r0", 32'hC000_0000);
    issue("s5_i1", 32'h2004);
    respond("s5_r1", 32'hC000_0001);
    issue("s5_i2", 32'h2008);
    respond("s5_r2", 32'hC000_0002);
    cyc();
    imem_rvalid = 1'b0; dec_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    #1;
    chk("s5_req", imem_req, 0); chk("s5_v", out_valid, 1);
    chk("s5_pc4", pcplus4_out, 32'h2004);
    issue("s5_new", 32'h3000);  chk("s5_flushed", out_valid, 0);
    respond("s5_r3", 32'hD000_0000);
    issue("s5_i4", 32'h3004);
    chk("s5_pc4_new", pcplus4_out, 32'h3004); chk("s5_ins_new", instr_out, 32'hD000_0000);

    // Reset during WAIT, late response after release
    cyc();
    resetn = 1'b0; imem_rvalid = 1'b0;
    #1;
    chk("s6_req", imem_req, 0); chk("s6_v", out_valid, 0);
    chk("s6_addr", imem_addr, 32'h0); chk("s6_ins", instr_out, 0);
    chk("s6_pc4", pcplus4_out, 0);
    cyc();
    resetn = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("s6_rel_req", imem_req, 1); chk("s6_rel_addr", imem_addr, 32'h0);
    idle_cyc();
    chk("s6_nopush", out_valid, 0); chk("s6_req2", imem_req, 1);
    chk("s6_addr2", imem_addr, 32'h0);
    issue("s6_i", 32'h0);
    respond("s6_r", 32'hE000_0000);
    idle_cyc();
    chk("s6_v3", out_valid, 1); chk("s6_pc4_3", pcplus4_out, 32'h4);
    chk("s6_ins3", instr_out, 32'hE000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
